// File: rtl/xor_pattern_checker_if.sv
// Stimulus/response bundle between the XOR pattern checker and its host and gate under test.
// The master modport is the checker side; the slave modport is the host and gate side.
interface xor_pattern_checker_if;
    logic       start;
    logic       a;
    logic       b;
    logic       y;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] fail_vec;
    logic [3:0] err_count;

    modport master (
        input  start, y,
        output a, b, busy, done, pass, fail_vec, err_count
    );

    modport slave (
        output start, y,
        input  a, b, busy, done, pass, fail_vec, err_count
    );
endinterface

// File: rtl/xor_pattern_checker.sv
// Drives a 2-input XOR through its four input patterns, samples y after a settle time,
// and reports per-pattern mismatches together with a saturating error count.
module xor_pattern_checker #(
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned LOOPS      = 1
) (
    input logic                   clk,
    input logic                   rst,
    xor_pattern_checker_if.master bus
);
    localparam int unsigned SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int unsigned LW = (LOOPS > 1) ? $clog2(LOOPS) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [LW-1:0] LOOP_LAST   = LW'(LOOPS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] settle_q, settle_d;
    logic [LW-1:0] loop_q, loop_d;
    logic [1:0]    pat_q, pat_d;
    logic [3:0]    acc_fail_q, acc_fail_d;
    logic [3:0]    acc_err_q, acc_err_d;
    logic [3:0]    fail_vec_q, fail_vec_d;
    logic [3:0]    err_count_q, err_count_d;
    logic          pass_q, pass_d;
    logic          sample;
    logic          mismatch;

    assign sample   = (settle_q == SETTLE_LAST);
    assign mismatch = (bus.y != (pat_q[1] ^ pat_q[0]));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            settle_q    <= '0;
            loop_q      <= '0;
            pat_q       <= '0;
            acc_fail_q  <= '0;
            acc_err_q   <= '0;
            fail_vec_q  <= '0;
            err_count_q <= '0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            loop_q      <= loop_d;
            pat_q       <= pat_d;
            acc_fail_q  <= acc_fail_d;
            acc_err_q   <= acc_err_d;
            fail_vec_q  <= fail_vec_d;
            err_count_q <= err_count_d;
            pass_q      <= pass_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        loop_d      = loop_q;
        pat_d       = pat_q;
        acc_fail_d  = acc_fail_q;
        acc_err_d   = acc_err_q;
        fail_vec_d  = fail_vec_q;
        err_count_d = err_count_q;
        pass_d      = pass_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d    = StRun;
                    settle_d   = '0;
                    loop_d     = '0;
                    pat_d      = '0;
                    acc_fail_d = '0;
                    acc_err_d  = '0;
                end
            end
            StRun: begin
                if (sample) begin
                    settle_d = '0;
                    if (mismatch) begin
                        acc_fail_d = acc_fail_q | (4'b0001 << pat_q);
                        if (acc_err_q != 4'hf) acc_err_d = acc_err_q + 4'd1;
                    end
                    if (pat_q == 2'd3) begin
                        pat_d = 2'd0;
                        if (loop_q == LOOP_LAST) begin
                            // Publish this sample's contribution too, not just the registered totals.
                            state_d     = StDone;
                            fail_vec_d  = acc_fail_d;
                            err_count_d = acc_err_d;
                            pass_d      = (acc_fail_d == 4'd0);
                        end else begin
                            loop_d = loop_q + LW'(1);
                        end
                    end else begin
                        pat_d = pat_q + 2'd1;
                    end
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign bus.a         = (state_q == StRun) & pat_q[1];
    assign bus.b         = (state_q == StRun) & pat_q[0];
    assign bus.busy      = (state_q == StRun);
    assign bus.done      = (state_q == StDone);
    assign bus.pass      = pass_q;
    assign bus.fail_vec  = fail_vec_q;
    assign bus.err_count = err_count_q;
endmodule
